icache_sa: RTL and testbench
============================

// Module: icache_sa
// PURPOSE
//  Parametrised set-associative instruction cache with multi-word lines; successor of the direct-mapped IFU cache.
//  Sits between instruction unit (IU) and memory controller (MC). Hits return same cycle.
//  Misses run a line-refill FSM that fetches LINE_WORDS consecutive words from MC and installs the whole line.
// PARAMETERS
//  RAM_ADDR_WIDTH  17  byte-address bits actually decoded; pc bits above are ignored
//  SET_WIDTH       6   log2(number of sets)
//  LINE_WIDTH      2   log2(words per line); LINE_WORDS = 2**LINE_WIDTH
//  WAYS            2   associativity; legal values 1 (direct-mapped) or 2
//  Constraint: SET_WIDTH+LINE_WIDTH+2 < RAM_ADDR_WIDTH (else elaboration $error)
// PORTS
//  clk_in            in   1   clock, rising edge
//  rst_in            in   1   reset, asynchronous, active-low
//  rdy_in            in   1   global enable; low = all state frozen, outputs hold
//  iu_to_ic_valid    in   1   IU fetch request valid
//  iu_to_ic_pc       in   32  fetch address (bits [1:0] ignored)
//  ic_to_iu_rdy      out  1   instruction valid this cycle for current pc
//  ic_to_iu_inst     out  32  instruction word
//  ic_to_mc_request  out  1   refill request, held high for entire line
//  ic_to_mc_addr     out  32  word address being requested
//  mc_to_ic_rdy      in   1   one-cycle pulse: mc_to_ic_inst holds word for ic_to_mc_addr
//  mc_to_ic_inst     in   32  returned word
// BEHAVIOUR
//  Address split: offset=pc[LINE_WIDTH+1:2], index=pc[SET_WIDTH+LINE_WIDTH+1:LINE_WIDTH+2], tag=pc[RAM_ADDR_WIDTH-1:SET_WIDTH+LINE_WIDTH+2].
//  Reset (rst_in=0, async): all valid bits 0, LRU bits 0, state IDLE, ic_to_mc_request=0, ic_to_mc_addr=0; tag/data arrays not reset.
//  hit = iu_to_ic_valid && any way valid with matching tag at index; ic_to_iu_rdy=hit (combinational, 0-cycle); inst from hitting way/offset.
//  ic_to_iu_rdy never asserted in REFILL/FILL, nor when iu_to_ic_valid=0; ic_to_iu_inst is don't-care when rdy=0.
//  FSM IDLE: valid && !hit -> latch line base (pc with offset=0) and index; request<=1, addr<=base; -> REFILL.
//  REFILL: each mc_to_ic_rdy writes word into line buffer slot cnt, cnt++, addr<=addr+4; after word LINE_WORDS-1: request<=0 -> FILL.
//  MC must not pulse mc_to_ic_rdy while request=0; such pulses are ignored.
//  FILL (1 cycle): write line buffer, tag, valid=1 into victim way -> IDLE. Next cycle the pc hits.
//  Miss latency = 1 (issue) + sum of MC word latencies + 1 (FILL) + 0 (hit) cycles.
//  Victim (WAYS=2): invalid way 0 first, then invalid way 1, else way != LRU-recent; LRU bit points at most-recently-used way,
//    updated on every hit (when in IDLE) and on FILL. WAYS=1: way 0 always, LRU logic absent.
//  pc change during REFILL: refill is not aborted; line completes and is installed; new pc evaluated in IDLE after FILL.
//  Line index is latched at miss; FILL uses latched index/tag, never current pc.
//  rdy_in=0: no state, counter, array or output register changes; mc_to_ic_rdy pulse in that cycle is lost (MC holds off while rdy_in=0).
//  Reset mid-refill: returns to IDLE, request drops asynchronously, partial line discarded, all lines invalid.
//  ic_to_mc_addr wraps naturally at 2**32; no special handling.
// CONFIGURATION
//  `ICACHE_PERF_EN defined: adds outputs ic_hit_cnt[31:0], ic_miss_cnt[31:0]; hit_cnt++ per cycle with hit in IDLE,
//    miss_cnt++ on IDLE->REFILL; reset to 0, wrap at 2**32, frozen when rdy_in=0.
//  Not defined: ports and counters absent; functional behaviour identical.
// STRUCTURE
//  consts.v: FSM state encodings (IC_IDLE=2'd0, IC_REFILL=2'd1, IC_FILL=2'd2), WORD_WIDTH=32.
//  Sub-module icache_way (one instance per way): valid/tag/data arrays, combinational lookup (hit, word), synchronous fill port.
//  Top holds FSM, line buffer, word counter, LRU bits, victim select, hit mux, MC interface.
// TESTING
//  1 Cold miss: pc=0x0000, MC returns 0x11,0x22,0x33,0x44 -> 4 requests addr 0x0,0x4,0x8,0xC; rdy with inst 0x11 one cycle after FILL.
//  2 Line reuse: after test 1, pc=0x4,0x8,0xC -> rdy same cycle, insts 0x22,0x33,0x44, request stays 0.
//  3 Conflict (WAYS=2,SET_WIDTH=6,LINE_WIDTH=2): fill 0x0000, 0x0400, touch 0x0000, fill 0x0800 -> 0x0400 evicted, 0x0000 and 0x0800 hit.
//  4 pc jump mid-refill: miss at 0x0100, switch pc to 0x0200 after 2 words -> 0x0100 line installed, then miss for 0x0200.
//  5 rdy_in=0 for 5 cycles mid-REFILL -> addr, cnt, request unchanged; resumes correctly when rdy_in=1.
//  6 rst_in low during REFILL -> request 0 immediately; prior hit pc 0x0000 now misses.

Source files
------------

// File: rtl/icache_sa_pkg.sv
// icache_sa_pkg : shared constants and FSM state type for the set-associative I-cache.
// Revision 1.0
`default_nettype none

package icache_sa_pkg;

   localparam int WORD_WIDTH = 32;

   typedef enum logic [1:0] {
      IC_IDLE   = 2'd0,
      IC_REFILL = 2'd1,
      IC_FILL   = 2'd2
   } ic_state_e;

endpackage

`default_nettype wire

// File: rtl/icache_sa_if.sv
// icache_sa_if : IU fetch port and MC refill port of the instruction cache.
// Revision 1.0
`default_nettype none

interface icache_sa_if;
   import icache_sa_pkg::*;

   logic                  iu_to_ic_valid;
   logic [WORD_WIDTH-1:0] iu_to_ic_pc;
   logic                  ic_to_iu_rdy;
   logic [WORD_WIDTH-1:0] ic_to_iu_inst;
   logic                  ic_to_mc_request;
   logic [WORD_WIDTH-1:0] ic_to_mc_addr;
   logic                  mc_to_ic_rdy;
   logic [WORD_WIDTH-1:0] mc_to_ic_inst;

   // Cache side
   modport slave (
      input  iu_to_ic_valid, iu_to_ic_pc, mc_to_ic_rdy, mc_to_ic_inst,
      output ic_to_iu_rdy, ic_to_iu_inst, ic_to_mc_request, ic_to_mc_addr
   );

   // IU / MC side
   modport master (
      output iu_to_ic_valid, iu_to_ic_pc, mc_to_ic_rdy, mc_to_ic_inst,
      input  ic_to_iu_rdy, ic_to_iu_inst, ic_to_mc_request, ic_to_mc_addr
   );

endinterface

`default_nettype wire

// File: rtl/icache_sa_way.sv
// icache_way : one cache way - valid/tag/data arrays, combinational lookup, synchronous line fill.
// Revision 1.0
`default_nettype none

module icache_way
   import icache_sa_pkg::*;
#(
   parameter int SET_WIDTH  = 6,
   parameter int LINE_WIDTH = 2,
   parameter int TAG_WIDTH  = 9
) (
   input  wire logic                                        clk_in,
   input  wire logic                                        rst_in,
   input  wire logic [SET_WIDTH-1:0]                        i_index,
   input  wire logic [TAG_WIDTH-1:0]                        i_tag,
   input  wire logic [LINE_WIDTH-1:0]                       i_offset,
   output logic                                             o_hit,
   output logic [WORD_WIDTH-1:0]                            o_word,
   input  wire logic [SET_WIDTH-1:0]                        i_fill_index,
   output logic                                             o_fill_valid,
   input  wire logic                                        i_fill_en,
   input  wire logic [TAG_WIDTH-1:0]                        i_fill_tag,
   input  wire logic [(2**LINE_WIDTH)-1:0][WORD_WIDTH-1:0]  i_fill_line
);

   localparam int C_SETS = 2**SET_WIDTH;

   logic [C_SETS-1:0]                               r_valid;
   logic [TAG_WIDTH-1:0]                            r_tag  [C_SETS];
   logic [(2**LINE_WIDTH)-1:0][WORD_WIDTH-1:0]      r_data [C_SETS];

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_valid <= '0;
      end else if (i_fill_en) begin
         r_valid[i_fill_index] <= 1'b1;
      end
   end

   // Tag and data storage carry no reset; the valid bit alone qualifies them.
   always_ff @(posedge clk_in) begin
      if (i_fill_en) begin
         r_tag[i_fill_index]  <= i_fill_tag;
         r_data[i_fill_index] <= i_fill_line;
      end
   end

   assign o_hit        = r_valid[i_index] && (r_tag[i_index] == i_tag);
   assign o_word       = r_data[i_index][i_offset];
   assign o_fill_valid = r_valid[i_fill_index];

endmodule

`default_nettype wire

// File: rtl/icache_sa.sv
// icache_sa : set-associative I-cache with line-refill FSM; `ICACHE_PERF_EN adds hit/miss counters.
// Revision 1.0
`default_nettype none

module icache_sa
   import icache_sa_pkg::*;
#(
   parameter int RAM_ADDR_WIDTH = 17,
   parameter int SET_WIDTH      = 6,
   parameter int LINE_WIDTH     = 2,
   parameter int WAYS           = 2
) (
   input  wire logic   clk_in,
   input  wire logic   rst_in,
   input  wire logic   rdy_in,
   icache_sa_if.slave  bus
`ifdef ICACHE_PERF_EN
   ,
   output logic [31:0] ic_hit_cnt,
   output logic [31:0] ic_miss_cnt
`endif
);

   localparam int C_IDX_LSB    = LINE_WIDTH + 2;
   localparam int C_TAG_LSB    = SET_WIDTH + LINE_WIDTH + 2;
   localparam int C_TAG_WIDTH  = RAM_ADDR_WIDTH - C_TAG_LSB;
   localparam int C_LINE_WORDS = 2**LINE_WIDTH;
   localparam int C_SETS       = 2**SET_WIDTH;
   localparam logic [LINE_WIDTH-1:0] C_LAST_WORD = '1;

   if (!(C_TAG_LSB < RAM_ADDR_WIDTH)) begin : g_bad_split
      $error("icache_sa: SET_WIDTH+LINE_WIDTH+2 must be below RAM_ADDR_WIDTH");
   end
   if (WAYS != 1 && WAYS != 2) begin : g_bad_ways
      $error("icache_sa: WAYS must be 1 or 2");
   end

   ic_state_e                                   r_state;
   ic_state_e                                   w_state_next;
   logic                                        r_req;
   logic [WORD_WIDTH-1:0]                       r_addr;
   logic [LINE_WIDTH-1:0]                       r_cnt;
   logic [SET_WIDTH-1:0]                        r_index;
   logic [C_TAG_WIDTH-1:0]                      r_tag;
   logic [C_LINE_WORDS-1:0][WORD_WIDTH-1:0]     r_line;

   logic [LINE_WIDTH-1:0]                       w_offset;
   logic [SET_WIDTH-1:0]                        w_index;
   logic [C_TAG_WIDTH-1:0]                      w_tag;
   logic [WORD_WIDTH-1:0]                       w_base;
   logic [WAYS-1:0]                             w_way_hit;
   logic [WAYS-1:0]                             w_way_valid;
   logic [WAYS-1:0]                             w_way_fill;
   logic [WORD_WIDTH-1:0]                       w_way_word [WAYS];
   logic [WORD_WIDTH-1:0]                       w_inst;
   logic                                        w_hit;
   logic                                        w_start;
   logic                                        w_take;
   logic                                        w_fill_en;

   assign w_offset = bus.iu_to_ic_pc[C_IDX_LSB-1:2];
   assign w_index  = bus.iu_to_ic_pc[C_TAG_LSB-1:C_IDX_LSB];
   assign w_tag    = bus.iu_to_ic_pc[RAM_ADDR_WIDTH-1:C_TAG_LSB];
   assign w_base   = {bus.iu_to_ic_pc[WORD_WIDTH-1:C_IDX_LSB], {C_IDX_LSB{1'b0}}};

   for (genvar gw = 0; gw < WAYS; gw++) begin : g_way
      icache_way #(
         .SET_WIDTH  (SET_WIDTH),
         .LINE_WIDTH (LINE_WIDTH),
         .TAG_WIDTH  (C_TAG_WIDTH)
      ) u_way (
         .clk_in       (clk_in),
         .rst_in       (rst_in),
         .i_index      (w_index),
         .i_tag        (w_tag),
         .i_offset     (w_offset),
         .o_hit        (w_way_hit[gw]),
         .o_word       (w_way_word[gw]),
         .i_fill_index (r_index),
         .o_fill_valid (w_way_valid[gw]),
         .i_fill_en    (w_way_fill[gw]),
         .i_fill_tag   (r_tag),
         .i_fill_line  (r_line)
      );
   end

   // Lookups are only honoured in IDLE so a half-built line can never answer.
   assign w_hit = bus.iu_to_ic_valid && (r_state == IC_IDLE) && (|w_way_hit);

   if (WAYS == 2) begin : g_lru
      logic [C_SETS-1:0] r_lru;
      logic              w_victim;

      always_comb begin
         w_victim = 1'b0;
         if (!w_way_valid[0]) begin
            w_victim = 1'b0;
         end else if (!w_way_valid[1]) begin
            w_victim = 1'b1;
         end else begin
            w_victim = ~r_lru[r_index];
         end
      end

      assign w_way_fill = {w_fill_en & w_victim, w_fill_en & ~w_victim};
      assign w_inst     = w_way_hit[1] ? w_way_word[1] : w_way_word[0];

      always_ff @(posedge clk_in or negedge rst_in) begin
         if (!rst_in) begin
            r_lru <= '0;
         end else if (w_fill_en) begin
            r_lru[r_index] <= w_victim;
         end else if (rdy_in && w_hit) begin
            r_lru[w_index] <= w_way_hit[1];
         end
      end
   end else begin : g_direct
      assign w_way_fill = w_fill_en;
      assign w_inst     = w_way_word[0];
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_state <= IC_IDLE;
      end else if (rdy_in) begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_start      = 1'b0;
      w_take       = 1'b0;
      w_fill_en    = 1'b0;
      case (r_state)
         IC_IDLE: begin
            if (bus.iu_to_ic_valid && !(|w_way_hit)) begin
               w_start      = 1'b1;
               w_state_next = IC_REFILL;
            end
         end
         IC_REFILL: begin
            if (bus.mc_to_ic_rdy && r_req) begin
               w_take = 1'b1;
               if (r_cnt == C_LAST_WORD) begin
                  w_state_next = IC_FILL;
               end
            end
         end
         IC_FILL: begin
            w_fill_en    = rdy_in;
            w_state_next = IC_IDLE;
         end
         default: begin
            w_state_next = IC_IDLE;
         end
      endcase
   end

   // Index and tag are latched at the miss so a pc change mid-refill cannot redirect the install.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_req   <= 1'b0;
         r_addr  <= '0;
         r_cnt   <= '0;
         r_index <= '0;
         r_tag   <= '0;
      end else if (rdy_in) begin
         if (w_start) begin
            r_req   <= 1'b1;
            r_addr  <= w_base;
            r_cnt   <= '0;
            r_index <= w_index;
            r_tag   <= w_tag;
         end else if (w_take) begin
            r_cnt  <= r_cnt + 1'b1;
            r_addr <= r_addr + 32'd4;
            if (r_cnt == C_LAST_WORD) begin
               r_req <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (rdy_in && w_take) begin
         r_line[r_cnt] <= bus.mc_to_ic_inst;
      end
   end

   assign bus.ic_to_iu_rdy     = w_hit;
   assign bus.ic_to_iu_inst    = w_inst;
   assign bus.ic_to_mc_request = r_req;
   assign bus.ic_to_mc_addr    = r_addr;

`ifdef ICACHE_PERF_EN
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         ic_hit_cnt  <= '0;
         ic_miss_cnt <= '0;
      end else if (rdy_in) begin
         if (w_hit) begin
            ic_hit_cnt <= ic_hit_cnt + 32'd1;
         end
         if (w_start) begin
            ic_miss_cnt <= ic_miss_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_icache_sa.sv
// tb_icache_sa : randomized scoreboard bench for icache_sa against a recency-list cache model.
// Revision 1.0
`default_nettype none

module tb_icache_sa;
   import icache_sa_pkg::*;

   localparam int NWAYS = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic rdy   = 1'b1;

   icache_sa_if bus ();

`ifdef ICACHE_PERF_EN
   logic [31:0] hit_cnt;
   logic [31:0] miss_cnt;
`endif

   icache_sa #(
      .RAM_ADDR_WIDTH (17),
      .SET_WIDTH      (6),
      .LINE_WIDTH     (2),
      .WAYS           (NWAYS)
   ) dut (
      .clk_in (clk),
      .rst_in (rst_n),
      .rdy_in (rdy),
      .bus    (bus)
`ifdef ICACHE_PERF_EN
      ,
      .ic_hit_cnt  (hit_cnt),
      .ic_miss_cnt (miss_cnt)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   always @(posedge clk) cyc++;

   // Backing memory contents and per-word MC response delay, both pure functions of address.
   function automatic logic [31:0] mem(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h5A5A0000 ^ (a >> 3);
   endfunction

   function automatic int mdly(input logic [31:0] a);
      logic [31:0] v;
      v = ((a >> 2) ^ (a >> 6)) % 32'd3;
      return int'(v);
   endfunction

   typedef struct {
      int          set;
      int          tag;
      logic [31:0] base;
   } line_t;

   typedef struct {
      logic [31:0] inst;
      int          lat;
   } exp_t;

   line_t       res[$];   // resident lines, most recently used first
   exp_t        sb[$];
   logic [31:0] mcq[$];
   exp_t        me;
   int          issue_cyc = 0;
   bit          got = 0;
   int          served = 0;

   task automatic m_lookup(input logic [31:0] pc, output bit hit, output logic [31:0] data);
      int          s;
      int          t;
      int          cnt;
      int          last;
      logic [31:0] off;
      line_t       e;
      s    = int'(pc[9:4]);
      t    = int'(pc[16:10]);
      off  = {28'd0, pc[3:2], 2'b00};
      hit  = 1'b0;
      for (int i = 0; i < res.size(); i++) begin
         if (res[i].set == s && res[i].tag == t) begin
            e = res[i];
            res.delete(i);
            res.push_front(e);
            hit = 1'b1;
            break;
         end
      end
      if (!hit) begin
         cnt  = 0;
         last = -1;
         for (int i = 0; i < res.size(); i++) begin
            if (res[i].set == s) begin
               cnt++;
               last = i;
            end
         end
         if (cnt >= NWAYS) res.delete(last);
         e.set  = s;
         e.tag  = t;
         e.base = {pc[31:4], 4'h0};
         res.push_front(e);
      end
      data = mem(res[0].base + off);
   endtask

   // Expected latency of a miss: issue cycle, each word (1 + MC delay), install cycle.
   task automatic issue(input logic [31:0] pc, input int extra);
      bit          h;
      logic [31:0] d;
      logic [31:0] a;
      int          lat;
      @(posedge clk); #1;
      m_lookup(pc, h, d);
      lat = 0;
      if (!h) begin
         lat = 2 + extra;
         for (int k = 0; k < 4; k++) begin
            a = {pc[31:4], 4'h0} + 32'(4 * k);
            mcq.push_back(a);
            lat += 1 + mdly(a);
         end
      end
      sb.push_back('{d, lat});
      got       = 1'b0;
      issue_cyc = cyc;
      bus.iu_to_ic_pc    = pc;
      bus.iu_to_ic_valid = 1'b1;
   endtask

   task automatic wait_done(input string name);
      int i;
      for (i = 0; i < 300; i++) begin
         @(negedge clk); #1;
         if (got) break;
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL timeout_%s: no ic_to_iu_rdy within 300 cycles (pc %h), required rdy", name, bus.iu_to_ic_pc);
         sb.delete();
         mcq.delete();
      end
   endtask

   task automatic drop();
      @(posedge clk); #1;
      bus.iu_to_ic_valid = 1'b0;
   endtask

   task automatic fetch(input logic [31:0] pc, input string name);
      issue(pc, 0);
      wait_done(name);
      drop();
   endtask

   // Monitor: pops the scoreboard whenever the cache answers.
   always @(negedge clk) begin
      if (rst_n) begin
         if (!bus.iu_to_ic_valid) begin
            checks++;
            if (bus.ic_to_iu_rdy) begin
               errors++;
               $display("FAIL rdy_idle: ic_to_iu_rdy=%b with valid=0, required 0", bus.ic_to_iu_rdy);
            end
         end else if (bus.ic_to_iu_rdy) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_rdy: pc %h answered with nothing outstanding", bus.iu_to_ic_pc);
            end else begin
               me = sb.pop_front();
               if (bus.ic_to_iu_inst !== me.inst) begin
                  errors++;
                  $display("FAIL inst pc %h: got %h, required %h", bus.iu_to_ic_pc, bus.ic_to_iu_inst, me.inst);
               end
               if (me.lat >= 0) begin
                  checks++;
                  if (cyc - issue_cyc != me.lat) begin
                     errors++;
                     $display("FAIL latency pc %h: got %0d cycles, required %0d", bus.iu_to_ic_pc, cyc - issue_cyc, me.lat);
                  end
               end
               got = 1'b1;
            end
         end
      end
   end

   // Memory-controller responder; verifies every requested address against the expected sequence.
   initial begin
      int rcnt;
      logic [31:0] ea;
      rcnt = -1;
      bus.mc_to_ic_rdy  = 1'b0;
      bus.mc_to_ic_inst = '0;
      forever begin
         @(posedge clk); #2;
         bus.mc_to_ic_rdy = 1'b0;
         if (!rst_n || !bus.ic_to_mc_request) begin
            rcnt = -1;
         end else begin
            if (rcnt < 0) rcnt = mdly(bus.ic_to_mc_addr);
            if (rdy) begin
               if (rcnt == 0) begin
                  checks++;
                  if (mcq.size() == 0) begin
                     errors++;
                     $display("FAIL mc_addr: request for %h with no refill expected", bus.ic_to_mc_addr);
                  end else begin
                     ea = mcq.pop_front();
                     if (bus.ic_to_mc_addr !== ea) begin
                        errors++;
                        $display("FAIL mc_addr: got %h, required %h", bus.ic_to_mc_addr, ea);
                     end
                  end
                  bus.mc_to_ic_inst = mem(bus.ic_to_mc_addr);
                  bus.mc_to_ic_rdy  = 1'b1;
                  served++;
                  rcnt = -1;
               end else begin
                  rcnt--;
               end
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   initial begin
      logic [31:0] cap_addr;
      logic [31:0] pc;
      bit          h;
      logic [31:0] d;
      int          s0;
      bus.iu_to_ic_valid = 1'b0;
      bus.iu_to_ic_pc    = '0;

      repeat (3) @(posedge clk);
      #1;
      chk("reset_request", 32'(bus.ic_to_mc_request), 32'd0);
      chk("reset_addr", bus.ic_to_mc_addr, 32'd0);
      @(negedge clk); #2;
      rst_n = 1'b1;

      // Cold miss, then reuse of the same line
      fetch(32'h0000, "cold");
      fetch(32'h0004, "reuse4");
      fetch(32'h0008, "reuse8");
      fetch(32'h000C, "reuseC");

      // Two-way conflict in set 0
      fetch(32'h0400, "conf400");
      fetch(32'h0000, "touch0");
      fetch(32'h0800, "fill800");
      fetch(32'h0000, "hit0");
      fetch(32'h0804, "hit800");
      fetch(32'h0400, "miss400");

      // pc switch mid-refill: old line still installed, new pc then misses
      s0 = served;
      @(posedge clk); #1;
      m_lookup(32'h0100, h, d);
      for (int k = 0; k < 4; k++) mcq.push_back(32'h0100 + 32'(4 * k));
      bus.iu_to_ic_pc    = 32'h0100;
      bus.iu_to_ic_valid = 1'b1;
      for (int i = 0; i < 100 && served < s0 + 2; i++) @(posedge clk);
      @(posedge clk); #1;
      m_lookup(32'h0200, h, d);
      for (int k = 0; k < 4; k++) mcq.push_back(32'h0200 + 32'(4 * k));
      sb.push_back('{d, -1});
      got = 1'b0;
      bus.iu_to_ic_pc = 32'h0200;
      wait_done("jump");
      drop();
      fetch(32'h0108, "jump_old_line");

      // rdy_in low for five cycles in the middle of a refill
      issue(32'h3000, 5);
      @(posedge clk);
      @(posedge clk); #1;
      rdy = 1'b0;
      cap_addr = bus.ic_to_mc_addr;
      chk("freeze_req_start", 32'(bus.ic_to_mc_request), 32'd1);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("freeze_addr", bus.ic_to_mc_addr, cap_addr);
         chk("freeze_req", 32'(bus.ic_to_mc_request), 32'd1);
      end
      rdy = 1'b1;
      wait_done("freeze");
      drop();

      // Randomized fetches over a few conflicting sets, with aliases above the decoded range
      for (int n = 0; n < 150; n++) begin
         pc = 32'(($urandom_range(0, 1) << 20) | ($urandom_range(0, 3) << 10)
                | ($urandom_range(0, 3) << 4) | ($urandom_range(0, 3) << 2));
         fetch(pc, "rand");
      end

      // Reset in the middle of a refill
      fetch(32'h0000, "pre_reset");
      issue(32'h03F0, 0);
      @(posedge clk);
      @(posedge clk); #3;
      bus.iu_to_ic_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("midreset_request", 32'(bus.ic_to_mc_request), 32'd0);
      chk("midreset_addr", bus.ic_to_mc_addr, 32'd0);
      res.delete();
      sb.delete();
      mcq.delete();
      @(negedge clk); #2;
      rst_n = 1'b1;
      fetch(32'h0000, "post_reset_miss");
      fetch(32'h0004, "post_reset_hit");

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
